// File: rtl/pwm_capture.sv
// pwm_capture
// Measures the period and high time of an incoming PWM waveform over a
// programmed number of periods. It is the receiving end of the timer_moore PWM
// output. The last measured values are read back through the same
// 2-bit address / CNT_W-bit data register interface the timer uses.
//
// Ports
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_start         arm a capture; only sampled while idle
//   i_we            register write strobe
//   i_addr          register address, shared by reads and writes
//   i_wdata         register write data
//   i_pwm           measured PWM input; may be asynchronous to i_clk
//   o_rdata         read data, combinational from i_addr
//   o_busy          high whenever a capture is armed or in progress
//   o_capture_done  one-cycle pulse when a capture ends, normally or on overflow
//   o_overflow      sticky; the counter saturated during the current/last capture
//
// Register map
//   0 (R)  period_reg  last full period in clock cycles
//   1 (R)  high_reg    last high time in clock cycles
//   2 (RW) num_reg     periods per capture; a written 0 is stored as 1
//   3 (R)  done_cnt    periods completed in the current/last capture
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_rdata,
  output logic             o_busy,
  output logic             o_capture_done,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONE = '1;

  state_t           state;
  logic             pwm_meta;
  logic             pwm_s;
  logic             pwm_d;
  logic             rise;
  logic             fall;
  logic             cnt_max;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] done_next;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] num_lat;

  // Two-flop synchronizer for the asynchronous PWM input, followed by one
  // delay flop so that edges can be detected on the synchronized signal.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_d    <= 1'b0;
    end else begin
      pwm_meta <= i_pwm;
      pwm_s    <= pwm_meta;
      pwm_d    <= pwm_s;
    end
  end

  assign rise      = pwm_s & ~pwm_d;
  assign fall      = ~pwm_s & pwm_d;
  assign cnt_max   = (cnt == ALL_ONE);
  assign done_next = done_cnt + ONE;
  assign o_busy    = (state != IDLE);

  // Period-count register. Writable at any time; the FSM only looks at the
  // copy taken when a capture is armed, so a write mid-capture is harmless.
  // Zero would mean "never finish", so it is promoted to one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_reg <= ONE;
    end else if (i_we && (i_addr == 2'd2)) begin
      num_reg <= (i_wdata == '0) ? ONE : i_wdata;
    end
  end

  // Measurement FSM. cnt restarts at 1 on each detected rise, so the value
  // held when the following fall (or rise) is seen equals the high time (or
  // period) in clock cycles. A saturated counter with no edge in that cycle
  // aborts the capture and leaves the previous measurements untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      period_reg     <= '0;
      high_reg       <= '0;
      done_cnt       <= '0;
      num_lat        <= ONE;
      o_capture_done <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      o_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            done_cnt   <= '0;
            o_overflow <= 1'b0;
            num_lat    <= num_reg;
            state      <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_reg <= cnt;
            cnt      <= cnt + ONE;
            state    <= MEAS_LOW;
          end else if (cnt_max) begin
            o_overflow     <= 1'b1;
            o_capture_done <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            period_reg <= cnt;
            done_cnt   <= done_next;
            cnt        <= ONE;
            if (done_next == num_lat) begin
              o_capture_done <= 1'b1;
              state          <= IDLE;
            end else begin
              state <= MEAS_HIGH;
            end
          end else if (cnt_max) begin
            o_overflow     <= 1'b1;
            o_capture_done <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux; combinational so software sees a value in the same cycle.
  always_comb begin
    o_rdata = period_reg;
    case (i_addr)
      2'd0:    o_rdata = period_reg;
      2'd1:    o_rdata = high_reg;
      2'd2:    o_rdata = num_reg;
      default: o_rdata = done_cnt;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Scoreboard bench for pwm_capture (instantiated with an 8-bit counter so that
// saturation is reachable quickly). A synchronous PWM generator drives i_pwm;
// every capture the stimulus starts pushes the expected result (period, high
// time, completed periods, overflow) onto a queue. An independent monitor pops
// an entry each time o_capture_done pulses and reads the registers back.
module tb_pwm_capture;

  localparam int CNT_W = 8;

  typedef struct {
    int period;
    int high;
    int done_cnt;
    int ovf;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic             i_we;
  logic [1:0]       i_addr;
  logic [CNT_W-1:0] i_wdata;
  logic             i_pwm;
  logic [CNT_W-1:0] o_rdata;
  logic             o_busy;
  logic             o_capture_done;
  logic             o_overflow;

  logic [1:0] stim_addr;
  logic [1:0] mon_addr;
  logic       stim_own;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   mon_seen = 0;
  int   last_period = 0;
  int   last_high   = 0;
  int   gen_mode  = 0;
  int   gen_p     = 10;
  int   gen_h     = 5;
  int   gen_phase = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // The stimulus owns the address bus only while it reads or writes.
  assign i_addr = stim_own ? stim_addr : mon_addr;

  always #5 i_clk = ~i_clk;

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_we           (i_we),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .i_pwm          (i_pwm),
    .o_rdata        (o_rdata),
    .o_busy         (o_busy),
    .o_capture_done (o_capture_done),
    .o_overflow     (o_overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // PWM source: mode 0 low, mode 1 periodic (gen_p / gen_h), mode 2 stuck high.
  initial begin
    i_pwm = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (gen_mode == 1) begin
        i_pwm     = (gen_phase < gen_h);
        gen_phase = (gen_phase + 1 >= gen_p) ? 0 : gen_phase + 1;
      end else begin
        i_pwm     = (gen_mode == 2);
        gen_phase = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    mon_addr = 2'd0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_capture_done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(o_capture_done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("overflow_at_done", 32'(o_overflow), 32'(mon_e.ovf));
          checkOutput("busy_at_done", 32'(o_busy), 32'd0);
          checkOutput("period_reg", 32'(o_rdata), 32'(mon_e.period));
          @(negedge i_clk);
          checkOutput("done_pulse_width", 32'(o_capture_done), 32'd0);
          mon_addr = 2'd1;
          #1;
          checkOutput("high_reg", 32'(o_rdata), 32'(mon_e.high));
          @(negedge i_clk);
          mon_addr = 2'd3;
          #1;
          checkOutput("done_cnt", 32'(o_rdata), 32'(mon_e.done_cnt));
          mon_addr = 2'd0;
        end
        mon_seen++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input int d);
    @(negedge i_clk);
    stim_own  = 1'b1;
    stim_addr = a;
    i_wdata   = CNT_W'(d);
    i_we      = 1'b1;
    @(negedge i_clk);
    i_we     = 1'b0;
    stim_own = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input int req);
    @(negedge i_clk);
    stim_own  = 1'b1;
    stim_addr = a;
    #1;
    checkOutput(name, 32'(o_rdata), 32'(req));
    stim_own = 1'b0;
  endtask

  // Pulses start for one cycle and checks the block reacted in the next cycle.
  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("busy_after_start", 32'(o_busy), 32'd1);
    checkOutput("overflow_cleared_on_start", 32'(o_overflow), 32'd0);
  endtask

  task automatic wait_done(input int target, input int bound);
    int k;
    k = 0;
    while (mon_seen < target && k < bound) begin
      @(negedge i_clk);
      k++;
    end
    checkOutput("capture_finished_in_time", 32'(mon_seen >= target), 32'd1);
    if (mon_seen < target) exp_q.delete();
  endtask

  // One full capture of a steady PWM of period p, high time h. The expected
  // result is simply the waveform parameters and the effective period count.
  task automatic applyStimulus(input int p, input int h, input int nwrite,
                               input bit arm_high, input bit extra_start);
    int   n_eff;
    int   target;
    int   k;
    exp_t e;
    n_eff = (nwrite == 0) ? 1 : nwrite;
    write_reg(2'd2, nwrite);
    gen_p    = p;
    gen_h    = h;
    gen_mode = 1;
    tick(2 * p + 8);
    if (arm_high) begin
      k = 0;
      while (i_pwm !== 1'b1 && k < 2 * p) begin
        tick(1);
        k++;
      end
      tick(6);
    end
    e.period    = p;
    e.high      = h;
    e.done_cnt  = n_eff;
    e.ovf       = 0;
    last_period = p;
    last_high   = h;
    exp_q.push_back(e);
    target = mon_seen + 1;
    pulse_start();
    if (extra_start) begin
      tick(p + 3);
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    wait_done(target, (n_eff + 3) * p + 40);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got 1, expected 0");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int   target;
    int   k;
    int   p;
    int   h;
    exp_t e;
    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_we      = 1'b0;
    i_wdata   = '0;
    stim_addr = 2'd0;
    stim_own  = 1'b0;

    // Reset state.
    tick(3);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_done", 32'(o_capture_done), 32'd0);
    checkOutput("reset_overflow", 32'(o_overflow), 32'd0);
    read_check("reset_period", 2'd0, 0);
    read_check("reset_high", 2'd1, 0);
    read_check("reset_num", 2'd2, 1);
    read_check("reset_done_cnt", 2'd3, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(2);

    // Basic capture, duty change, armed while high, start while busy.
    applyStimulus(20, 10, 2, 1'b0, 1'b0);
    applyStimulus(10, 2, 1, 1'b0, 1'b0);
    applyStimulus(40, 20, 1, 1'b1, 1'b0);
    applyStimulus(30, 8, 3, 1'b0, 1'b1);

    // Writes to read-only addresses are ignored.
    write_reg(2'd0, 77);
    write_reg(2'd1, 55);
    read_check("ro_period", 2'd0, 30);
    read_check("ro_high", 2'd1, 8);

    // Overflow: the input rises and then stays high beyond the counter range.
    gen_mode = 0;
    tick(5);
    e.period   = last_period;
    e.high     = last_high;
    e.done_cnt = 0;
    e.ovf      = 1;
    exp_q.push_back(e);
    target = mon_seen + 1;
    pulse_start();
    tick(3);
    gen_mode = 2;
    wait_done(target, 400);
    tick(40);
    gen_mode = 0;
    tick(10);
    checkOutput("overflow_sticky", 32'(o_overflow), 32'd1);
    checkOutput("idle_after_overflow", 32'(o_busy), 32'd0);

    // Randomized captures.
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(120, 6);
      h = $urandom_range(p - 2, 2);
      applyStimulus(p, h, $urandom_range(3, 1), 1'b0, 1'b0);
    end

    // Reset in the middle of a capture, while measuring the low phase.
    write_reg(2'd2, 3);
    gen_p    = 40;
    gen_h    = 10;
    gen_mode = 1;
    tick(90);
    pulse_start();
    k = 0;
    while (i_pwm !== 1'b0 && k < 100) begin tick(1); k++; end
    while (i_pwm !== 1'b1 && k < 100) begin tick(1); k++; end
    while (i_pwm !== 1'b0 && k < 100) begin tick(1); k++; end
    tick(8);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(o_busy), 32'd0);
    checkOutput("midreset_done", 32'(o_capture_done), 32'd0);
    checkOutput("midreset_period", 32'(o_rdata), 32'd0);
    tick(2);
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    last_period = 0;
    last_high   = 0;
    read_check("midreset_high", 2'd1, 0);
    read_check("midreset_done_cnt", 2'd3, 0);
    read_check("midreset_num", 2'd2, 1);
    tick(100);
    checkOutput("idle_after_midreset", 32'(o_busy), 32'd0);

    // A period count of zero behaves as one.
    write_reg(2'd2, 0);
    read_check("num_zero_reads_one", 2'd2, 1);
    applyStimulus(26, 13, 0, 1'b0, 1'b0);

    tick(5);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
